mvm_inst_seq: RTL and testbench

Instruction sequencer that sits directly upstream of the matrix-vector PE (`mvm_pe`). It fetches 80-bit layer instructions from a synchronous instruction memory, starting at a programmable base address. Each instruction is presented to the PE over its valid/ready port, and the sequencer waits for the PE to report completion before fetching the next one. It runs a whole network (load → layers → save) from one `start` pulse and terminates on a HALT opcode or an error.

---
 rtl/mvm_pkg.sv | 37 +++
 rtl/mvm_inst_check.sv | 13 +
 rtl/mvm_inst_seq.sv | 127 ++++++++++++
 tb/tb_mvm_inst_seq.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mvm_pkg.sv
// Shared definitions for the matrix-vector sequencer and PE: opcodes, instruction field offsets, sequencer states.
package mvm_pkg;

  localparam int INST_W_DEF = 80;

  localparam logic [3:0] OP_HALT  = 4'd0;
  localparam logic [3:0] OP_LAYER = 4'd1;
  localparam logic [3:0] OP_CHAIN = 4'd2;
  localparam logic [3:0] OP_SAVE  = 4'd3;

  localparam int OP_MSB   = 79;
  localparam int OP_LSB   = 76;
  localparam int DIMI_MSB = 63;
  localparam int DIMI_LSB = 56;
  localparam int DIMO_MSB = 55;
  localparam int DIMO_LSB = 48;
  localparam int BIAS_MSB = 41;
  localparam int BIAS_LSB = 32;
  localparam int WGT_MSB  = 27;
  localparam int WGT_LSB  = 16;
  localparam int DIO_MSB  = 15;
  localparam int DIO_LSB  = 0;

  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_FETCH,
    SEQ_LATCH,
    SEQ_ISSUE,
    SEQ_WAIT,
    SEQ_DONE
  } seq_state_t;

  function automatic logic op_is_legal(input logic [3:0] op);
    return (op <= OP_SAVE);
  endfunction

endpackage

// File: rtl/mvm_inst_check.sv
// Combinational opcode decode of a fetched instruction: HALT detect and legality, zero latency, no flow control.
module mvm_inst_check
  import mvm_pkg::*;
(
  input  logic [3:0] op,
  output logic       is_halt,
  output logic       is_illegal
);

  assign is_halt    = (op == OP_HALT);
  assign is_illegal = !op_is_legal(op);

endmodule

// File: rtl/mvm_inst_seq.sv
// Sequencer fetching instructions from sync IMEM into mvm_pe; first pe_valid 3 cycles after start, held until pe_ready.
// Optional busy-cycle counter on perf_cycles when MVM_SEQ_PERF_EN is defined (tied to 0 otherwise).
module mvm_inst_seq
  import mvm_pkg::*;
#(
  parameter int INST_W  = 80,
  parameter int IMEM_AW = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [IMEM_AW-1:0] base_pc,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [15:0]        inst_cnt,
  output logic               imem_rd,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [INST_W-1:0]  imem_dat,
  output logic               pe_valid,
  input  logic               pe_ready,
  output logic [INST_W-1:0]  pe_inst,
  output logic [31:0]        perf_cycles
);

  localparam logic [IMEM_AW-1:0] PC_LAST = '1;
  localparam logic [IMEM_AW-1:0] PC_ONE  = {{(IMEM_AW-1){1'b0}}, 1'b1};

  seq_state_t         state_q, state_d;
  logic [IMEM_AW-1:0] pc_q;
  logic [INST_W-1:0]  pe_inst_q;
  logic               err_q;
  logic [15:0]        inst_cnt_q;
  logic               wait_mask_q;

  logic op_halt, op_illegal;
  logic start_acc, pe_hs, wait_done;

  mvm_inst_check u_check (
    .op         (imem_dat[OP_MSB:OP_LSB]),
    .is_halt    (op_halt),
    .is_illegal (op_illegal)
  );

  assign start_acc = (state_q == SEQ_IDLE) && start;
  assign pe_hs     = (state_q == SEQ_ISSUE) && pe_ready;
  // The PE only drops ready the cycle after it accepts, so the first WAIT cycle is ignored.
  assign wait_done = (state_q == SEQ_WAIT) && !wait_mask_q && pe_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEQ_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SEQ_IDLE:  if (start) state_d = SEQ_FETCH;
      SEQ_FETCH: state_d = SEQ_LATCH;
      SEQ_LATCH: state_d = (op_halt || op_illegal) ? SEQ_DONE : SEQ_ISSUE;
      SEQ_ISSUE: if (pe_ready) state_d = SEQ_WAIT;
      SEQ_WAIT:  if (wait_done) state_d = (pc_q == PC_LAST) ? SEQ_DONE : SEQ_FETCH;
      SEQ_DONE:  state_d = SEQ_IDLE;
      default:   state_d = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= '0;
      pe_inst_q   <= '0;
      err_q       <= 1'b0;
      inst_cnt_q  <= '0;
      wait_mask_q <= 1'b0;
    end else begin
      wait_mask_q <= pe_hs;
      if (start_acc) begin
        pc_q       <= base_pc;
        err_q      <= 1'b0;
        inst_cnt_q <= '0;
      end
      if (state_q == SEQ_LATCH) begin
        pe_inst_q <= imem_dat;
        if (op_illegal) err_q <= 1'b1;
      end
      if (pe_hs && (inst_cnt_q != 16'hFFFF)) begin
        inst_cnt_q <= inst_cnt_q + 16'd1;
      end
      // Reaching the top of IMEM without a HALT is a program error, not a wrap.
      if (wait_done) begin
        if (pc_q == PC_LAST) err_q <= 1'b1;
        else                 pc_q  <= pc_q + PC_ONE;
      end
    end
  end

  assign busy      = (state_q != SEQ_IDLE);
  assign done      = (state_q == SEQ_DONE);
  assign imem_rd   = (state_q == SEQ_FETCH);
  assign imem_addr = (state_q == SEQ_FETCH) ? pc_q : '0;
  assign pe_valid  = (state_q == SEQ_ISSUE);
  assign pe_inst   = pe_inst_q;
  assign err       = err_q;
  assign inst_cnt  = inst_cnt_q;

`ifdef MVM_SEQ_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_q <= '0;
    end else if (start_acc) begin
      perf_q <= '0;
    end else if (busy && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_mvm_inst_seq.sv
// Directed bench for mvm_inst_seq: one 8-bit-address instance plus a 2-bit-address instance for the wrap case.
module tb_mvm_inst_seq;
  import mvm_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // main instance (IMEM_AW = 8)
  logic        start = 1'b0;
  logic [7:0]  base_pc = '0;
  logic        busy, done, err, imem_rd, pe_valid;
  logic [15:0] inst_cnt;
  logic [7:0]  imem_addr;
  logic [79:0] imem_dat = '0;
  logic        pe_ready = 1'b1;
  logic [79:0] pe_inst;
  logic [31:0] perf_cycles;

  // wrap instance (IMEM_AW = 2)
  logic        start_w = 1'b0;
  logic [1:0]  base_pc_w = '0;
  logic        busy_w, done_w, err_w, imem_rd_w, pe_valid_w;
  logic [15:0] inst_cnt_w;
  logic [1:0]  imem_addr_w;
  logic [79:0] imem_dat_w = '0;
  logic        pe_ready_w = 1'b1;
  logic [79:0] pe_inst_w;
  logic [31:0] perf_cycles_w;

  mvm_inst_seq #(.INST_W(80), .IMEM_AW(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_pc(base_pc),
    .busy(busy), .done(done), .err(err), .inst_cnt(inst_cnt),
    .imem_rd(imem_rd), .imem_addr(imem_addr), .imem_dat(imem_dat),
    .pe_valid(pe_valid), .pe_ready(pe_ready), .pe_inst(pe_inst),
    .perf_cycles(perf_cycles)
  );

  mvm_inst_seq #(.INST_W(80), .IMEM_AW(2)) dut_w (
    .clk(clk), .rst_n(rst_n), .start(start_w), .base_pc(base_pc_w),
    .busy(busy_w), .done(done_w), .err(err_w), .inst_cnt(inst_cnt_w),
    .imem_rd(imem_rd_w), .imem_addr(imem_addr_w), .imem_dat(imem_dat_w),
    .pe_valid(pe_valid_w), .pe_ready(pe_ready_w), .pe_inst(pe_inst_w),
    .perf_cycles(perf_cycles_w)
  );

  localparam logic [79:0] I_L1   = 80'h1000_0F0E_0012_0345_6789;
  localparam logic [79:0] I_CH   = 80'h2A5A_5A5A_5A5A_5A5A_5A5A;
  localparam logic [79:0] I_SV   = 80'h3FFF_FFFF_FFFF_FFFF_FFFF;
  localparam logic [79:0] I_HALT = 80'h0000_0000_0000_0000_0000;
  localparam logic [79:0] I_BAD  = 80'h7123_4567_89AB_CDEF_0123;
  localparam logic [79:0] I_L1B  = 80'h1BEE_F000_0000_0000_0001;

  logic [79:0] imem   [256];
  logic [79:0] imem_w [4];

  // synchronous instruction memories
  always @(posedge clk) begin
    if (imem_rd)   imem_dat   <= imem[imem_addr];
    if (imem_rd_w) imem_dat_w <= imem_w[imem_addr_w];
  end

  int hs_cnt = 0, done_cnt = 0, rd_cnt = 0, hs_cnt_w = 0;
  always @(negedge clk) begin
    if (pe_valid && pe_ready) hs_cnt++;
    if (done) done_cnt++;
    if (imem_rd) rd_cnt++;
    if (pe_valid_w && pe_ready_w) hs_cnt_w++;
  end

  int n_checks = 0, n_pass = 0;
  int cyc = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic to_cycle(input int n);
    while (cyc < n) tick();
  endtask

  task automatic go(input logic [7:0] b);
    start = 1'b1; base_pc = b; cyc = 0;
    tick();
    start = 1'b0;
  endtask

  task automatic go_w(input logic [1:0] b);
    start_w = 1'b1; base_pc_w = b; cyc = 0;
    tick();
    start_w = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++; if (busy !== 1'b0) $display("FAIL reset busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0 || err !== 1'b0) $display("FAIL reset done/err: got %b/%b want 0/0", done, err); else n_pass++;
    n_checks++; if (imem_rd !== 1'b0 || imem_addr !== 8'd0) $display("FAIL reset imem: got rd=%b addr=%0d want 0/0", imem_rd, imem_addr); else n_pass++;
    n_checks++; if (pe_valid !== 1'b0 || pe_inst !== 80'd0) $display("FAIL reset pe: got v=%b inst=%h want 0/0", pe_valid, pe_inst); else n_pass++;
    n_checks++; if (inst_cnt !== 16'd0 || perf_cycles !== 32'd0) $display("FAIL reset counters: got %0d/%0d want 0/0", inst_cnt, perf_cycles); else n_pass++;
  endtask

  task automatic test_single_layer();
    int d0;
    d0 = done_cnt;
    pe_ready = 1'b1;
    go(8'd0);
    n_checks++; if (imem_rd !== 1'b1 || imem_addr !== 8'd0 || busy !== 1'b1) $display("FAIL single fetch: got rd=%b addr=%0d busy=%b want 1/0/1", imem_rd, imem_addr, busy); else n_pass++;
    tick();
    n_checks++; if (pe_valid !== 1'b0) $display("FAIL single valid_early: got %b want 0", pe_valid); else n_pass++;
    tick();
    n_checks++; if (pe_valid !== 1'b1 || pe_inst !== I_L1) $display("FAIL single issue_c3: got v=%b inst=%h want 1/%h", pe_valid, pe_inst, I_L1); else n_pass++;
    tick();
    pe_ready = 1'b0;
    n_checks++; if (inst_cnt !== 16'd1) $display("FAIL single inst_cnt: got %0d want 1", inst_cnt); else n_pass++;
    repeat (19) tick();
    n_checks++; if (busy !== 1'b1 || pe_valid !== 1'b0 || imem_rd !== 1'b0) $display("FAIL single waiting: got busy=%b v=%b rd=%b want 1/0/0", busy, pe_valid, imem_rd); else n_pass++;
    tick();
    pe_ready = 1'b1;
    tick();
    n_checks++; if (imem_rd !== 1'b1 || imem_addr !== 8'd1) $display("FAIL single halt_fetch: got rd=%b addr=%0d want 1/1", imem_rd, imem_addr); else n_pass++;
    to_cycle(27);
    n_checks++; if (done !== 1'b1) $display("FAIL single done_c27: got %b want 1", done); else n_pass++;
    tick();
    n_checks++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) $display("FAIL single end: got busy=%b done=%b err=%b want 0/0/0", busy, done, err); else n_pass++;
    n_checks++; if (done_cnt - d0 !== 1) $display("FAIL single done_pulses: got %0d want 1", done_cnt - d0); else n_pass++;
  endtask

  task automatic test_full_network();
    int r0;
    r0 = rd_cnt;
    pe_ready = 1'b1;
    go(8'd4);
    to_cycle(3);
    n_checks++; if (pe_valid !== 1'b1 || pe_inst !== I_L1) $display("FAIL net inst0: got v=%b %h want 1/%h", pe_valid, pe_inst, I_L1); else n_pass++;
    to_cycle(7);
    n_checks++; if (pe_valid !== 1'b0) $display("FAIL net mask_gap: got %b want 0", pe_valid); else n_pass++;
    to_cycle(8);
    n_checks++; if (pe_valid !== 1'b1 || pe_inst !== I_CH) $display("FAIL net inst1: got v=%b %h want 1/%h", pe_valid, pe_inst, I_CH); else n_pass++;
    to_cycle(13);
    n_checks++; if (pe_valid !== 1'b1 || pe_inst !== I_SV) $display("FAIL net inst2: got v=%b %h want 1/%h", pe_valid, pe_inst, I_SV); else n_pass++;
    to_cycle(16);
    n_checks++; if (imem_rd !== 1'b1 || imem_addr !== 8'd7) $display("FAIL net halt_fetch: got rd=%b addr=%0d want 1/7", imem_rd, imem_addr); else n_pass++;
    to_cycle(18);
    n_checks++; if (done !== 1'b1 || err !== 1'b0) $display("FAIL net done: got done=%b err=%b want 1/0", done, err); else n_pass++;
    to_cycle(19);
    n_checks++; if (busy !== 1'b0 || inst_cnt !== 16'd3) $display("FAIL net end: got busy=%b cnt=%0d want 0/3", busy, inst_cnt); else n_pass++;
    n_checks++; if (rd_cnt - r0 !== 4) $display("FAIL net rd_count: got %0d want 4", rd_cnt - r0); else n_pass++;
`ifdef MVM_SEQ_PERF_EN
    n_checks++; if (perf_cycles !== 32'd18) $display("FAIL net perf: got %0d want 18", perf_cycles); else n_pass++;
`else
    n_checks++; if (perf_cycles !== 32'd0) $display("FAIL net perf: got %0d want 0", perf_cycles); else n_pass++;
`endif
  endtask

  task automatic test_backpressure();
    int h0;
    h0 = hs_cnt;
    pe_ready = 1'b0;
    go(8'd8);
    to_cycle(3);
    for (int i = 0; i < 6; i++) begin
      pe_ready = (i == 5);
      n_checks++; if (pe_valid !== 1'b1 || pe_inst !== I_SV) $display("FAIL bp stable%0d: got v=%b %h want 1/%h", i, pe_valid, pe_inst, I_SV); else n_pass++;
      tick();
    end
    pe_ready = 1'b0;
    n_checks++; if (pe_valid !== 1'b0 || inst_cnt !== 16'd1) $display("FAIL bp after_hs: got v=%b cnt=%0d want 0/1", pe_valid, inst_cnt); else n_pass++;
    n_checks++; if (hs_cnt - h0 !== 1) $display("FAIL bp handshakes: got %0d want 1", hs_cnt - h0); else n_pass++;
    tick();
    pe_ready = 1'b1;
    to_cycle(13);
    n_checks++; if (done !== 1'b1) $display("FAIL bp done_c13: got %b want 1", done); else n_pass++;
    to_cycle(14);
  endtask

  task automatic test_illegal();
    int h0;
    h0 = hs_cnt;
    pe_ready = 1'b1;
    go(8'd12);
    to_cycle(3);
    n_checks++; if (done !== 1'b1 || err !== 1'b1 || pe_valid !== 1'b0) $display("FAIL illegal done: got done=%b err=%b v=%b want 1/1/0", done, err, pe_valid); else n_pass++;
    to_cycle(4);
    n_checks++; if (busy !== 1'b0 || err !== 1'b1 || inst_cnt !== 16'd0) $display("FAIL illegal sticky: got busy=%b err=%b cnt=%0d want 0/1/0", busy, err, inst_cnt); else n_pass++;
    n_checks++; if (hs_cnt - h0 !== 0) $display("FAIL illegal no_issue: got %0d want 0", hs_cnt - h0); else n_pass++;
    go(8'd9);
    n_checks++; if (err !== 1'b0) $display("FAIL illegal err_clear: got %b want 0", err); else n_pass++;
    to_cycle(3);
    n_checks++; if (done !== 1'b1 || err !== 1'b0) $display("FAIL illegal halt_run: got done=%b err=%b want 1/0", done, err); else n_pass++;
    to_cycle(4);
  endtask

  task automatic test_wrap();
    pe_ready_w = 1'b1;
    go_w(2'd0);
    to_cycle(18);
    n_checks++; if (pe_valid_w !== 1'b1 || pe_inst_w !== I_L1B) $display("FAIL wrap inst3: got v=%b %h want 1/%h", pe_valid_w, pe_inst_w, I_L1B); else n_pass++;
    to_cycle(20);
    n_checks++; if (busy_w !== 1'b1 || done_w !== 1'b0 || err_w !== 1'b0) $display("FAIL wrap pre: got busy=%b done=%b err=%b want 1/0/0", busy_w, done_w, err_w); else n_pass++;
    to_cycle(21);
    n_checks++; if (done_w !== 1'b1 || err_w !== 1'b1) $display("FAIL wrap done: got done=%b err=%b want 1/1", done_w, err_w); else n_pass++;
    to_cycle(22);
    n_checks++; if (busy_w !== 1'b0 || inst_cnt_w !== 16'd4 || hs_cnt_w !== 4) $display("FAIL wrap end: got busy=%b cnt=%0d hs=%0d want 0/4/4", busy_w, inst_cnt_w, hs_cnt_w); else n_pass++;
`ifdef MVM_SEQ_PERF_EN
    n_checks++; if (perf_cycles_w !== 32'd21) $display("FAIL wrap perf: got %0d want 21", perf_cycles_w); else n_pass++;
`else
    n_checks++; if (perf_cycles_w !== 32'd0) $display("FAIL wrap perf: got %0d want 0", perf_cycles_w); else n_pass++;
`endif
  endtask

  task automatic test_reset_mid_wait();
    pe_ready = 1'b1;
    go(8'd0);
    to_cycle(4);
    pe_ready = 1'b0;
    to_cycle(5);
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || pe_valid !== 1'b0 || imem_rd !== 1'b0) $display("FAIL rstmid ctrl: got busy=%b done=%b err=%b v=%b rd=%b want all 0", busy, done, err, pe_valid, imem_rd); else n_pass++;
    n_checks++; if (pe_inst !== 80'd0 || inst_cnt !== 16'd0 || perf_cycles !== 32'd0) $display("FAIL rstmid data: got inst=%h cnt=%0d perf=%0d want 0/0/0", pe_inst, inst_cnt, perf_cycles); else n_pass++;
    pe_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    go(8'd0);
    to_cycle(3);
    n_checks++; if (pe_valid !== 1'b1 || pe_inst !== I_L1) $display("FAIL rstmid rerun_issue: got v=%b %h want 1/%h", pe_valid, pe_inst, I_L1); else n_pass++;
    to_cycle(8);
    n_checks++; if (done !== 1'b1 || err !== 1'b0) $display("FAIL rstmid rerun_done: got done=%b err=%b want 1/0", done, err); else n_pass++;
    to_cycle(9);
    n_checks++; if (inst_cnt !== 16'd1 || busy !== 1'b0) $display("FAIL rstmid rerun_end: got cnt=%0d busy=%b want 1/0", inst_cnt, busy); else n_pass++;
`ifdef MVM_SEQ_PERF_EN
    n_checks++; if (perf_cycles !== 32'd8) $display("FAIL rstmid perf: got %0d want 8", perf_cycles); else n_pass++;
`else
    n_checks++; if (perf_cycles !== 32'd0) $display("FAIL rstmid perf: got %0d want 0", perf_cycles); else n_pass++;
`endif
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = I_HALT;
    imem[0]  = I_L1;   imem[1]  = I_HALT;
    imem[4]  = I_L1;   imem[5]  = I_CH;   imem[6] = I_SV; imem[7] = I_HALT;
    imem[8]  = I_SV;   imem[9]  = I_HALT;
    imem[12] = I_BAD;
    imem_w[0] = I_L1;  imem_w[1] = I_CH;  imem_w[2] = I_SV; imem_w[3] = I_L1B;

    repeat (3) tick();
    test_reset();
    rst_n = 1'b1;
    repeat (2) tick();
    test_single_layer();
    tick();
    test_full_network();
    tick();
    test_backpressure();
    tick();
    test_illegal();
    tick();
    test_wrap();
    tick();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

endmodule
